note_hit_judge: RTL and testbench
=================================

Name: note_hit_judge

Overview:
- Upstream stage of the score counter in the LED-matrix rhythm game.
- Tracks the timing window of the two note lanes and judges button presses as hit or miss.
- Produces the one-cycle 2-bit judge code and the 8-bit combo count that the score counter consumes every clock.

Parameters:
- WINDOW_CYCLES, 8: hit window length in clk cycles per note; legal range 2..255.
- DEBOUNCE_CYCLES, 4: stable-level cycles required by the debouncer. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset. Single clock domain.
- note_arrive  in  2  per-lane one-cycle pulse; a note entered the judge line. Bit0 = lane0, bit1 = lane1.
- btn  in  2  per-lane button level, already synchronous to clk.
- judge  out  2  per-lane one-cycle hit pulse. 01/10 = single lane hit, 11 = both lanes, 00 = none.
- combo  out  8  consecutive-hit count, saturating.
- miss  out  2  per-lane one-cycle miss pulse.
- max_combo  out  8  highest combo reached since reset.

Behaviour:
- Reset values: judge=0, combo=0, miss=0, max_combo=0, both lane FSMs in IDLE, window counters 0.
- Edge-detect register btn_prev resets to 2'b11, so a button held through reset produces no edge.
- Press edge: btn[i]=1 and btn_prev[i]=0 in cycle t.
- Per-lane FSM states:
  - IDLE: waiting for a note.
  - WINDOW: counter cnt counts down from WINDOW_CYCLES-1.
- IDLE transitions:
  - note_arrive[i] in cycle N: window is open in cycles N..N+WINDOW_CYCLES-1 inclusive; enter WINDOW.
  - A press edge in the same cycle N counts as a hit.
  - A press edge with no open window is ignored: no judge, no miss, combo unchanged.
- WINDOW transitions:
  - Press edge in cycle t: judge[i]=1 in cycle t+1; go to IDLE.
  - cnt reaches 0 with no edge: miss[i]=1 in the following cycle; go to IDLE.
  - An edge in the last window cycle is a hit, not a miss.
- Re-arrival: note_arrive[i] while in WINDOW with no edge that cycle means the old note is a miss (miss[i] next cycle) and the window restarts at full length. If an edge is present that cycle, the old note is a hit and the new window opens at full length.
- All outputs are registered; latency is 1 cycle from the deciding cycle. judge and miss are never high longer than one cycle per event.
- Combo update in cycle t+1, where h = number of lane hits decided in cycle t (0..2):
  - Any miss decided in t: combo <= h.
  - Otherwise: combo <= min(combo + h, 255). Compute with a 9-bit sum, then saturate.
  - Both lanes hit together add 2.
- max_combo <= max(max_combo, next combo), updated in the same cycle as combo.
- Reset asserted mid-window: the note is dropped and no miss is reported.

Optional Feature:
- Macro: NOTE_HIT_JUDGE_DEBOUNCE_EN.
- Defined:
  - Each btn bit passes through a debouncer whose filtered level changes only after the raw level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Edge detection runs on the filtered level.
  - Press latency grows by DEBOUNCE_CYCLES cycles.
  - Filtered level resets to 1.
- Undefined: raw btn feeds edge detection directly; no debounce logic is present.

Decomposition:
- Shared package (game_pkg) holds:
  - LANES=2.
  - COMBO_W=8, COMBO_MAX=8'd255.
  - Judge codes JUDGE_NONE=2'b00, JUDGE_L0=2'b01, JUDGE_L1=2'b10, JUDGE_BOTH=2'b11.
  - The lane FSM state typedef (IDLE, WINDOW).
- Sub-module lane_judge_fsm:
  - Instantiated once per lane.
  - Inputs: note_arrive, press_edge.
  - Outputs: hit/miss decision pulses.
- The top level owns edge detection, the optional debouncer, combo/max_combo arithmetic and output registers.

Test Plan (WINDOW_CYCLES=8, macro undefined unless stated):
- Basic hit: note_arrive=01 at cycle 10, btn[0] rises at cycle 13 -> judge=01 at cycle 14 only; combo 0->1.
- Timeout: note_arrive=10 at cycle 10, no press -> miss=10 at cycle 18; judge stays 0; combo reset to 0. A press at cycle 17 instead gives judge=10 at cycle 18.
- Dual hit and saturation:
  - Both lanes arrive and press together -> judge=11, combo +2.
  - Preload combo 254 through hits, then a dual hit -> combo=255, max_combo=255.
- Mixed cycle: lane0 hit and lane1 timeout decided in the same cycle with combo=20 -> judge=01, miss=10, combo=1, max_combo stays 20.
- Edge cases:
  - Press with no window -> no outputs.
  - Button held through reset release -> no judge.
  - Reset asserted at window cycle 5 -> no miss afterwards; all outputs 0.
- With NOTE_HIT_JUDGE_DEBOUNCE_EN, DEBOUNCE_CYCLES=4:
  - A 2-cycle btn glitch -> no judge.
  - A clean press at cycle 12 -> filtered edge at cycle 16, judge at 17 if the window is still open.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the rhythm-game judge path: lane count, combo
// width and ceiling, judge codes and the per-lane FSM state type.
package game_pkg;

    localparam int         LANES     = 2;
    localparam int         COMBO_W   = 8;
    localparam logic [7:0] COMBO_MAX = 8'd255;

    localparam logic [1:0] JUDGE_NONE = 2'b00;
    localparam logic [1:0] JUDGE_L0   = 2'b01;
    localparam logic [1:0] JUDGE_L1   = 2'b10;
    localparam logic [1:0] JUDGE_BOTH = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        WINDOW = 1'b1
    } lane_state_t;

endpackage

// File: rtl/lane_judge_fsm.sv
// One note lane: opens a hit window on note arrival and decides hit or
// miss for the note. The decision pulses are combinational for the
// deciding cycle; the top level registers them.
module lane_judge_fsm
    import game_pkg::*;
#(
    parameter int WINDOW_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic note_arrive,
    input  logic press_edge,
    output logic hit,
    output logic miss
);

    // The arrival cycle is the first window cycle, so the counter is
    // loaded one below WINDOW_CYCLES-1 and hits 0 in the last window cycle.
    localparam logic [7:0] CNT_LOAD = 8'(WINDOW_CYCLES - 2);

    lane_state_t state, state_next;
    logic [7:0]  cnt, cnt_next;

    // State and window counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and hit/miss decision for the current cycle
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hit        = 1'b0;
        miss       = 1'b0;
        case (state)
            IDLE: begin
                if (note_arrive) begin
                    if (press_edge) begin
                        hit = 1'b1;
                    end else begin
                        state_next = WINDOW;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            WINDOW: begin
                if (press_edge) begin
                    hit = 1'b1;
                    if (note_arrive) begin
                        cnt_next = CNT_LOAD;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = 8'd0;
                    end
                end else if (note_arrive) begin
                    miss     = 1'b1;
                    cnt_next = CNT_LOAD;
                end else if (cnt == 8'd0) begin
                    miss       = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

endmodule

// File: rtl/note_hit_judge.sv
// Note hit judge: press-edge detection, two lane FSMs, registered
// judge/miss pulses and saturating combo / max_combo tracking.
// Optional button debouncer enabled by defining NOTE_HIT_JUDGE_DEBOUNCE_EN.
module note_hit_judge
    import game_pkg::*;
#(
    parameter int WINDOW_CYCLES   = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LANES-1:0]   note_arrive,
    input  logic [LANES-1:0]   btn,
    output logic [1:0]         judge,
    output logic [COMBO_W-1:0] combo,
    output logic [LANES-1:0]   miss,
    output logic [COMBO_W-1:0] max_combo
);

    if (WINDOW_CYCLES < 2 || WINDOW_CYCLES > 255) begin : g_bad_window
        $error("WINDOW_CYCLES must be in 2..255");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    function automatic logic [COMBO_W-1:0] sat_combo(input logic [COMBO_W:0] sum);
        return sum[COMBO_W] ? COMBO_MAX : sum[COMBO_W-1:0];
    endfunction

    logic [LANES-1:0] btn_lvl;
    logic [LANES-1:0] btn_prev;

`ifdef NOTE_HIT_JUDGE_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [LANES-1:0] btn_filt;
    logic [DB_W-1:0]  db_cnt [LANES];

    // Filtered level follows the raw level only after a sustained difference
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (reset) begin
                btn_filt[i] <= 1'b1;
                db_cnt[i]   <= '0;
            end else if (btn[i] != btn_filt[i]) begin
                if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    btn_filt[i] <= btn[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end else begin
                db_cnt[i] <= '0;
            end
        end
    end

    assign btn_lvl = btn_filt;
`else
    assign btn_lvl = btn;
`endif

    // ---- p0: deciding cycle (edge detect, lane decisions, combo math)
    logic [LANES-1:0]   press_edge_p0;
    logic [LANES-1:0]   hit_p0;
    logic [LANES-1:0]   miss_p0;
    logic [1:0]         hit_cnt_p0;
    logic [COMBO_W:0]   combo_sum_p0;
    logic [COMBO_W-1:0] combo_next_p0;
    logic [COMBO_W-1:0] max_next_p0;

    assign press_edge_p0 = btn_lvl & ~btn_prev;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_judge_fsm #(
            .WINDOW_CYCLES (WINDOW_CYCLES)
        ) u_fsm (
            .clk         (clk),
            .reset       (reset),
            .note_arrive (note_arrive[i]),
            .press_edge  (press_edge_p0[i]),
            .hit         (hit_p0[i]),
            .miss        (miss_p0[i])
        );
    end

    assign hit_cnt_p0    = {1'b0, hit_p0[0]} + {1'b0, hit_p0[1]};
    assign combo_sum_p0  = {1'b0, combo} + {{(COMBO_W - 1){1'b0}}, hit_cnt_p0};
    assign combo_next_p0 = (|miss_p0) ? {{(COMBO_W - 2){1'b0}}, hit_cnt_p0}
                                      : sat_combo(combo_sum_p0);
    assign max_next_p0   = (combo_next_p0 > max_combo) ? combo_next_p0 : max_combo;

    // ---- p1: registered outputs
    // Edge history starts high so a button held through reset is not a press
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev  <= '1;
            judge     <= JUDGE_NONE;
            miss      <= '0;
            combo     <= '0;
            max_combo <= '0;
        end else begin
            btn_prev  <= btn_lvl;
            judge     <= hit_p0;
            miss      <= miss_p0;
            combo     <= combo_next_p0;
            max_combo <= max_next_p0;
        end
    end

endmodule

// File: tb/tb_note_hit_judge.sv
// Bench for note_hit_judge: directed vector table, hand sequences for
// saturation (or debounce when NOTE_HIT_JUDGE_DEBOUNCE_EN is defined) and
// randomized stimulus against a deadline-based reference model.
module tb_note_hit_judge;

    localparam int W  = 8;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] note_arrive = 2'b00;
    logic [1:0] btn = 2'b11;
    logic [1:0] judge;
    logic [1:0] miss;
    logic [7:0] combo;
    logic [7:0] max_combo;

    always #5 clk = ~clk;

    note_hit_judge #(
        .WINDOW_CYCLES   (W),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .note_arrive (note_arrive),
        .btn         (btn),
        .judge       (judge),
        .combo       (combo),
        .miss        (miss),
        .max_combo   (max_combo)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each lane holds an absolute closing cycle.
    int         cyc = 0;
    logic [1:0] m_prev = 2'b11;
    bit         m_act [2];
    int         m_close [2];
    int         m_combo = 0;
    int         m_max = 0;
    logic [1:0] m_j = 2'b00;
    logic [1:0] m_m = 2'b00;
`ifdef NOTE_HIT_JUDGE_DEBOUNCE_EN
    logic [1:0] m_filt = 2'b11;
    int         m_run [2];
`endif

    task automatic model_step(input logic rst, input logic [1:0] na, input logic [1:0] b);
        logic [1:0] lvl, edg, hit, ms;
        bit open;
        int h;
        if (rst) begin
            m_prev = 2'b11;
            for (int i = 0; i < 2; i++) m_act[i] = 0;
            m_combo = 0;
            m_max   = 0;
            m_j     = 2'b00;
            m_m     = 2'b00;
`ifdef NOTE_HIT_JUDGE_DEBOUNCE_EN
            m_filt = 2'b11;
            for (int i = 0; i < 2; i++) m_run[i] = 0;
`endif
        end else begin
`ifdef NOTE_HIT_JUDGE_DEBOUNCE_EN
            lvl = m_filt;
            for (int i = 0; i < 2; i++) begin
                if (b[i] != m_filt[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_filt[i] = b[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
`else
            lvl = b;
`endif
            edg    = lvl & ~m_prev;
            m_prev = lvl;
            for (int i = 0; i < 2; i++) begin
                open   = m_act[i] && (cyc <= m_close[i]);
                hit[i] = edg[i] && (open || na[i]);
                ms[i]  = open && !edg[i] && (na[i] || cyc == m_close[i]);
                if (na[i] && !(edg[i] && !open)) begin
                    m_act[i]   = 1;
                    m_close[i] = cyc + W - 1;
                end else if (hit[i] || (open && cyc == m_close[i])) begin
                    m_act[i] = 0;
                end
            end
            h = int'(hit[0]) + int'(hit[1]);
            if (|ms) m_combo = h;
            else     m_combo = (m_combo + h > 255) ? 255 : m_combo + h;
            if (m_combo > m_max) m_max = m_combo;
            m_j = hit;
            m_m = ms;
        end
        cyc++;
    endtask

    task automatic drive(input logic rst, input logic [1:0] na, input logic [1:0] b);
        reset       = rst;
        note_arrive = na;
        btn         = b;
        model_step(rst, na, b);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic [1:0] j, input logic [1:0] m,
                           input logic [7:0] c, input logic [7:0] mx);
        chk({nm, ".judge"}, {6'b0, judge}, {6'b0, j});
        chk({nm, ".miss"}, {6'b0, miss}, {6'b0, m});
        chk({nm, ".combo"}, combo, c);
        chk({nm, ".max_combo"}, max_combo, mx);
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] na;
        logic [1:0] b;
        logic [1:0] j;
        logic [1:0] m;
        logic [7:0] c;
        logic [7:0] mx;
    } vec_t;

    vec_t tbl[$];

    function automatic void addn(int n, logic rst, logic [1:0] na, logic [1:0] b,
                                 logic [1:0] j, logic [1:0] m, logic [7:0] c, logic [7:0] mx);
        vec_t v;
        v.rst = rst; v.na = na; v.b = b; v.j = j; v.m = m; v.c = c; v.mx = mx;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    initial begin
`ifndef NOTE_HIT_JUDGE_DEBOUNCE_EN
        addn(2,  1, 2'b00, 2'b11, 2'b00, 2'b00, 0, 0);  // reset, button held
        addn(1,  0, 2'b00, 2'b11, 2'b00, 2'b00, 0, 0);  // held through release
        addn(1,  0, 2'b01, 2'b11, 2'b00, 2'b00, 0, 0);  // lane0 note, still held
        addn(2,  0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        addn(1,  0, 2'b00, 2'b01, 2'b01, 2'b00, 1, 1);  // lane0 hit
        addn(1,  0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1);
        addn(1,  0, 2'b00, 2'b01, 2'b00, 2'b00, 1, 1);  // press, no window
        addn(1,  0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1);
        addn(1,  0, 2'b10, 2'b00, 2'b00, 2'b00, 1, 1);  // lane1 note
        addn(6,  0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1);
        addn(1,  0, 2'b00, 2'b00, 2'b00, 2'b10, 0, 1);  // lane1 timeout
        addn(1,  0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
        addn(1,  0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1);  // both lanes
        addn(1,  0, 2'b00, 2'b11, 2'b11, 2'b00, 2, 2);  // dual hit
        addn(1,  0, 2'b00, 2'b00, 2'b00, 2'b00, 2, 2);
        addn(1,  0, 2'b10, 2'b00, 2'b00, 2'b00, 2, 2);  // lane1 note
        addn(6,  0, 2'b00, 2'b00, 2'b00, 2'b00, 2, 2);
        addn(1,  0, 2'b00, 2'b10, 2'b10, 2'b00, 3, 3);  // hit in last window cycle
        addn(1,  0, 2'b00, 2'b00, 2'b00, 2'b00, 3, 3);
        addn(1,  0, 2'b01, 2'b01, 2'b01, 2'b00, 4, 4);  // arrive + press together
        addn(9,  0, 2'b00, 2'b00, 2'b00, 2'b00, 4, 4);  // no stray miss
        addn(1,  0, 2'b10, 2'b00, 2'b00, 2'b00, 4, 4);
        addn(1,  0, 2'b01, 2'b00, 2'b00, 2'b00, 4, 4);
        addn(5,  0, 2'b00, 2'b00, 2'b00, 2'b00, 4, 4);
        addn(1,  0, 2'b00, 2'b01, 2'b01, 2'b10, 1, 4);  // mixed hit + timeout
        addn(1,  0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4);
        addn(1,  0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 4);
        addn(2,  0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4);
        addn(1,  0, 2'b01, 2'b00, 2'b00, 2'b01, 0, 4);  // re-arrival miss
        addn(6,  0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4);
        addn(1,  0, 2'b00, 2'b01, 2'b01, 2'b00, 1, 4);  // hit on restarted window
        addn(1,  0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4);
        addn(1,  0, 2'b10, 2'b00, 2'b00, 2'b00, 1, 4);
        addn(4,  0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4);
        addn(1,  1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);  // reset mid-window
        addn(10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);  // note dropped, no miss

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].na, tbl[i].b);
            chk_all($sformatf("vec%0d", i), tbl[i].j, tbl[i].m, tbl[i].c, tbl[i].mx);
        end

        // Climb to 254 with dual hits, then saturate.
        for (int k = 1; k <= 127; k++) begin
            drive(0, 2'b11, 2'b11);
            chk_all($sformatf("sat_hit%0d", k), 2'b11, 2'b00, 8'(2 * k), 8'(2 * k));
            drive(0, 2'b00, 2'b00);
            chk_all($sformatf("sat_gap%0d", k), 2'b00, 2'b00, 8'(2 * k), 8'(2 * k));
        end
        drive(0, 2'b11, 2'b11);
        chk_all("sat_dual", 2'b11, 2'b00, 255, 255);
        drive(0, 2'b00, 2'b00);
        drive(0, 2'b01, 2'b01);
        chk_all("sat_hold", 2'b01, 2'b00, 255, 255);
        drive(0, 2'b00, 2'b00);
        drive(0, 2'b10, 2'b00);
        for (int k = 0; k < 6; k++) drive(0, 2'b00, 2'b00);
        drive(0, 2'b00, 2'b00);
        chk_all("sat_miss", 2'b00, 2'b10, 0, 255);
`else
        drive(1, 2'b00, 2'b00);
        drive(1, 2'b00, 2'b00);
        chk_all("db_reset", 2'b00, 2'b00, 0, 0);
        for (int k = 0; k < 6; k++) drive(0, 2'b00, 2'b00);
        chk_all("db_settle", 2'b00, 2'b00, 0, 0);
        drive(0, 2'b01, 2'b00);
        drive(0, 2'b00, 2'b01);
        drive(0, 2'b00, 2'b01);
        for (int k = 3; k < 7; k++) begin
            drive(0, 2'b00, 2'b00);
            chk($sformatf("db_glitch%0d.judge", k), {6'b0, judge}, 8'd0);
        end
        drive(0, 2'b00, 2'b00);
        chk("db_glitch.miss", {6'b0, miss}, 8'd1);
        drive(0, 2'b00, 2'b00);
        drive(0, 2'b00, 2'b00);
        drive(0, 2'b01, 2'b00);             // note at c10
        drive(0, 2'b00, 2'b00);
        for (int k = 12; k < 16; k++) begin  // clean press from c12
            drive(0, 2'b00, 2'b01);
            chk($sformatf("db_press%0d.judge", k), {6'b0, judge}, 8'd0);
        end
        drive(0, 2'b00, 2'b01);             // filtered edge at c16
        chk("db_press16.judge", {6'b0, judge}, 8'd1);
        chk("db_press16.combo", combo, 8'd1);
        for (int k = 0; k < 10; k++) drive(0, 2'b00, 2'b00);
`endif

        // Randomized run against the reference model.
        drive(1, 2'b00, 2'b11);
        drive(1, 2'b00, 2'b11);
        chk_all("rnd_reset", 2'b00, 2'b00, 0, 0);
        begin
            logic [1:0] rb, rna;
            logic       rr;
            rb = 2'b11;
            for (int n = 0; n < 4000; n++) begin
                for (int i = 0; i < 2; i++) begin
                    rna[i] = ($urandom % 7) == 0;
                    if (($urandom % 3) == 0) rb[i] = ~rb[i];
                end
                rr = ($urandom % 600) == 0;
                drive(rr, rna, rb);
                chk_all($sformatf("rnd%0d", n), m_j, m_m, 8'(m_combo), 8'(m_max));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
